// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave with one-entry AW/W/AR holders and fully backpressurable B/R.
// Optional macro AXIL_MEM_RO_REGION_EN makes word indices [RO_BASE, RO_LIMIT] read-only.
module axil_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int RO_BASE    = 0,
    parameter int RO_LIMIT   = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    AW_VALID,
    output logic                    AW_READY,
    input  logic [ADDR_WIDTH-1:0]   AW_ADDR,
    input  logic                    W_VALID,
    output logic                    W_READY,
    input  logic [DATA_WIDTH-1:0]   W_DATA,
    input  logic [DATA_WIDTH/8-1:0] W_STRB,
    output logic                    B_VALID,
    input  logic                    B_READY,
    output logic [1:0]              B_RESP,
    input  logic                    AR_VALID,
    output logic                    AR_READY,
    input  logic [ADDR_WIDTH-1:0]   AR_ADDR,
    output logic                    R_VALID,
    input  logic                    R_READY,
    output logic [DATA_WIDTH-1:0]   R_DATA,
    output logic [1:0]              R_RESP
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFFS;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic              aw_full_q, aw_full_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              ar_full_q, ar_full_d;
    logic [IDX_W-1:0]  ar_idx_q, ar_idx_d;

    logic              aw_ready_q, w_ready_q, ar_ready_q;
    logic              b_valid_q, b_valid_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic              r_valid_q, r_valid_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

    logic aw_hs, w_hs, ar_hs;
    logic commit, issue;
    logic aw_oor, ar_oor, aw_ro;
    logic wr_en;
    logic [MEM_AW-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{AW_ADDR[OFFS-1:0], AR_ADDR[OFFS-1:0]};

    assign aw_hs = AW_VALID && aw_ready_q;
    assign w_hs  = W_VALID && w_ready_q;
    assign ar_hs = AR_VALID && ar_ready_q;

    assign commit = aw_full_q && w_full_q && !b_valid_q;
    assign issue  = ar_full_q && (!r_valid_q || R_READY);

    assign aw_oor = {1'b0, aw_idx_q} >= (IDX_W + 1)'(MEM_DEPTH);
    assign ar_oor = {1'b0, ar_idx_q} >= (IDX_W + 1)'(MEM_DEPTH);

`ifdef AXIL_MEM_RO_REGION_EN
    assign aw_ro = ({1'b0, aw_idx_q} >= (IDX_W + 1)'(RO_BASE)) &&
                   ({1'b0, aw_idx_q} <= (IDX_W + 1)'(RO_LIMIT));
`else
    logic unused_ro_params;
    assign unused_ro_params = (RO_BASE > RO_LIMIT);
    assign aw_ro = 1'b0;
`endif

    // A commit landing on a reset edge is dropped so no partial write reaches memory.
    assign wr_en   = commit && !aw_oor && !aw_ro && !ARESET;
    assign wr_addr = aw_idx_q[MEM_AW-1:0];
    assign rd_addr = ar_idx_q[MEM_AW-1:0];

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ar_full_d = ar_full_q;
        ar_idx_d  = ar_idx_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        r_valid_d = r_valid_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = AW_ADDR[ADDR_WIDTH-1:OFFS];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = W_DATA;
            w_strb_d = W_STRB;
        end

        if (b_valid_q && B_READY) begin
            b_valid_d = 1'b0;
        end
        if (commit) begin
            b_valid_d = 1'b1;
            if (aw_oor) begin
                b_resp_d = RESP_DECERR;
            end else if (aw_ro) begin
                b_resp_d = RESP_SLVERR;
            end else begin
                b_resp_d = RESP_OKAY;
            end
        end

        if (issue) begin
            ar_full_d = 1'b0;
        end
        if (ar_hs) begin
            ar_full_d = 1'b1;
            ar_idx_d  = AR_ADDR[ADDR_WIDTH-1:OFFS];
        end

        if (r_valid_q && R_READY) begin
            r_valid_d = 1'b0;
        end
        if (issue) begin
            r_valid_d = 1'b1;
            r_resp_d  = ar_oor ? RESP_DECERR : RESP_OKAY;
            r_data_d  = ar_oor ? '0 : rd_word;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ar_full_q  <= 1'b0;
            ar_idx_q   <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            ar_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            ar_full_q  <= ar_full_d;
            ar_idx_q   <= ar_idx_d;
            // Registered so READY stays low through reset and tracks "holder empty" afterwards.
            aw_ready_q <= !aw_full_d;
            w_ready_q  <= !w_full_d;
            ar_ready_q <= !ar_full_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            r_valid_q  <= r_valid_d;
            r_resp_q   <= r_resp_d;
            r_data_q   <= r_data_d;
        end
    end

    // One byte-wide RAM per lane keeps strobed writes to a single driver each.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] mem_q [MEM_DEPTH];

            always_ff @(posedge ACLK) begin
                if (wr_en && w_strb_q[gi]) begin
                    mem_q[wr_addr] <= w_data_q[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = mem_q[rd_addr];
        end
    endgenerate

    assign AW_READY = aw_ready_q;
    assign W_READY  = w_ready_q;
    assign AR_READY = ar_ready_q;
    assign B_VALID  = b_valid_q;
    assign B_RESP   = b_resp_q;
    assign R_VALID  = r_valid_q;
    assign R_RESP   = r_resp_q;
    assign R_DATA   = r_data_q;

endmodule
